// File: rtl/cv32e40p_irq_source.sv
// Interrupt source: latches peripheral events into PENDING and drives level irq lines to the core.
// Optional macro CV32E40P_IRQ_SOURCE_SYNC_EN selects a 2-flop input synchronizer instead of one register.
module cv32e40p_irq_source #(
   parameter logic [31:0] IRQ_MASK = 32'hFFFF_0888
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] event_i,
   output logic [31:0] irq_o,
   input  logic        irq_ack_i,
   input  logic [4:0]  irq_id_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o
);

   // Bus handshake: every req_i is granted in the same cycle and answered by
   // exactly one rvalid_o pulse on the following cycle; there is no back-pressure.
   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_CLEAR   = 2'd1;
   localparam logic [1:0] REG_MODE    = 2'd2;
   localparam logic [1:0] REG_ENABLE  = 2'd3;

   logic [31:0] ev_s_q, ev_p_q;
   logic [31:0] pending_q, pending_d;
   logic [31:0] mode_q, mode_d;
   logic [31:0] enable_q, enable_d;
   logic        rvalid_q;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] rise, set_mask, clr_mask, ack_mask, rd_val;
   logic [1:0]  sel;
   logic        wr_en, rd_en;
   logic        unused_addr;

   assign sel         = addr_i[3:2];
   assign wr_en       = req_i & we_i;
   assign rd_en       = req_i & ~we_i;
   assign unused_addr = ^addr_i[1:0];

`ifdef CV32E40P_IRQ_SOURCE_SYNC_EN
   logic [31:0] sync1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         ev_s_q  <= '0;
      end else begin
         sync1_q <= event_i;
         ev_s_q  <= sync1_q;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ev_s_q <= '0;
      else        ev_s_q <= event_i;
   end
`endif

   // Rising edges only count for lines in edge mode; level lines are never latched.
   assign rise     = ev_s_q & ~ev_p_q & mode_q;
   assign ack_mask = irq_ack_i ? (32'd1 << irq_id_i) : 32'd0;

   always_comb begin
      set_mask = rise;
      clr_mask = ack_mask;
      mode_d   = mode_q;
      enable_d = enable_q;
      if (wr_en) begin
         case (sel)
            REG_PENDING: set_mask = rise | wdata_i;
            REG_CLEAR:   clr_mask = ack_mask | wdata_i;
            REG_MODE:    mode_d   = wdata_i & IRQ_MASK;
            default:     enable_d = wdata_i & IRQ_MASK;
         endcase
      end
      // Set is applied after clear so a same-cycle set always wins.
      pending_d = ((pending_q & ~clr_mask) | set_mask) & IRQ_MASK;
   end

   always_comb begin
      case (sel)
         REG_PENDING: rd_val = pending_q;
         REG_CLEAR:   rd_val = 32'd0;
         REG_MODE:    rd_val = mode_q;
         REG_ENABLE:  rd_val = enable_q;
         default:     rd_val = 32'd0;
      endcase
      rdata_d = rd_en ? (rd_val & IRQ_MASK) : 32'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ev_p_q    <= '0;
         pending_q <= '0;
         mode_q    <= '0;
         enable_q  <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         ev_p_q    <= ev_s_q;
         pending_q <= pending_d;
         mode_q    <= mode_d;
         enable_q  <= enable_d;
         rvalid_q  <= req_i;
         rdata_q   <= rdata_d;
      end
   end

   assign irq_o    = enable_q & ((mode_q & pending_q) | (~mode_q & (ev_s_q | pending_q))) & IRQ_MASK;
   assign gnt_o    = req_i;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;

endmodule
